// File: rtl/fft_r2_iter_if.sv
// Frame transfer bundle for the iterative FFT engine: one full input frame
// and one full output frame, each with its own valid/ready handshake.
interface fft_r2_iter_if #(
   parameter int N = 32,
   parameter int W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [N*2*W-1:0]     in_data;
   logic                 inverse;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*2*W-1:0]     out_data;

   // Producer/consumer side (drives frames in, drains results).
   modport master (
      output in_valid, in_data, inverse, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Engine side.
   modport slave (
      input  in_valid, in_data, inverse, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT: one butterfly per clock over an
// N-point register bank, LOG2N stages, results presented in natural order.
module fft_r2_iter #(
   parameter int N     = 32,
   parameter int W     = 16,
   parameter int SCALE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   fft_r2_iter_if.slave            bus,
   output logic [$clog2(N)-2:0]    tw_addr,
   input  logic signed [W:0]       tw_re,
   input  logic signed [W:0]       tw_im,
   output logic                    busy,
   output logic                    ovf
);
   localparam int LOG2N = $clog2(N);
   localparam int SW    = $clog2(LOG2N);
   localparam int PW    = 2*W + 2;
   localparam int SWD   = W + 2;

   // Saturation bounds at butterfly-sum width.
   localparam logic signed [SWD-1:0] HI = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [SWD-1:0] LO = {3'b111, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

   state_t                  state_q;
   logic                    rdy_q, vld_q, busy_q;
   logic [N-1:0][W-1:0]     re_q, im_q;
   logic [SW-1:0]           stg_q;
   logic [LOG2N-2:0]        bfy_q;
   logic                    inv_q, ovf_q;

   logic [LOG2N-1:0]        b_ext, hmask, j_idx, top_idx, bot_idx;
   logic signed [W-1:0]     a_re, a_im, b_re, b_im;
   logic signed [W:0]       w_re, w_im;
   logic signed [PW-1:0]    p_re, p_im;
   logic signed [SWD-1:0]   t_re, t_im, s_re, s_im, d_re, d_im;
   logic [3:0][W:0]         sat_r;
   logic [W-1:0]            nt_re, nt_im, nb_re, nb_im;
   logic                    clip;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
      logic [LOG2N-1:0] r;
      for (int k = 0; k < LOG2N; k++) r[k] = x[LOG2N-1-k];
      return r;
   endfunction

   // {clip, value}: clamp a W+2-bit sum into W bits.
   function automatic logic [W:0] sat(input logic signed [SWD-1:0] v);
      if (v > HI)      return {1'b1, HI[W-1:0]};
      else if (v < LO) return {1'b1, LO[W-1:0]};
      else             return {1'b0, v[W-1:0]};
   endfunction

   // Butterfly addressing: top/bot indices and twiddle index from {stage, butterfly}.
   always_comb begin
      b_ext   = {1'b0, bfy_q};
      hmask   = (LOG2N'(1) << stg_q) - LOG2N'(1);
      j_idx   = b_ext & hmask;
      top_idx = ((b_ext & ~hmask) << 1) | j_idx;
      bot_idx = top_idx | (LOG2N'(1) << stg_q);
      tw_addr = (state_q == COMP) ? (LOG2N-1)'(j_idx << (SW'(LOG2N - 1) - stg_q)) : '0;
   end

   // Butterfly datapath: complex twiddle multiply, sum/difference, scale or saturate.
   always_comb begin
      a_re  = re_q[top_idx];
      a_im  = im_q[top_idx];
      b_re  = re_q[bot_idx];
      b_im  = im_q[bot_idx];
      w_re  = tw_re;
      w_im  = inv_q ? -tw_im : tw_im;
      p_re  = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
      p_im  = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
      t_re  = SWD'(p_re >>> (W - 1));
      t_im  = SWD'(p_im >>> (W - 1));
      s_re  = SWD'(a_re) + t_re;
      s_im  = SWD'(a_im) + t_im;
      d_re  = SWD'(a_re) - t_re;
      d_im  = SWD'(a_im) - t_im;
      sat_r = '0;
      clip  = 1'b0;
      if (SCALE != 0) begin
         nt_re = s_re[W:1];
         nt_im = s_im[W:1];
         nb_re = d_re[W:1];
         nb_im = d_im[W:1];
      end else begin
         sat_r[0] = sat(s_re);
         sat_r[1] = sat(s_im);
         sat_r[2] = sat(d_re);
         sat_r[3] = sat(d_im);
         nt_re = sat_r[0][W-1:0];
         nt_im = sat_r[1][W-1:0];
         nb_re = sat_r[2][W-1:0];
         nb_im = sat_r[3][W-1:0];
         clip  = sat_r[0][W] | sat_r[1][W] | sat_r[2][W] | sat_r[3][W];
      end
   end

   // Control FSM, bank load/write-back, stage counters and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         stg_q   <= '0;
         bfy_q   <= '0;
         inv_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               for (int i = 0; i < N; i++) begin
                  re_q[bitrev(LOG2N'(i))] <= bus.in_data[2*W*i +: W];
                  im_q[bitrev(LOG2N'(i))] <= bus.in_data[2*W*i+W +: W];
               end
               inv_q   <= bus.inverse;
               ovf_q   <= 1'b0;
               stg_q   <= '0;
               bfy_q   <= '0;
               state_q <= COMP;
               rdy_q   <= 1'b0;
               busy_q  <= 1'b1;
            end
            COMP: begin
               re_q[top_idx] <= nt_re;
               im_q[top_idx] <= nt_im;
               re_q[bot_idx] <= nb_re;
               im_q[bot_idx] <= nb_im;
               ovf_q         <= ovf_q | clip;
               bfy_q         <= bfy_q + 1'b1;
               if (bfy_q == '1) begin
                  stg_q <= stg_q + 1'b1;
                  if (stg_q == SW'(LOG2N - 1)) begin
                     stg_q   <= '0;
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     vld_q   <= 1'b1;
                  end
               end
            end
            DONE: if (bus.out_ready) begin
               state_q <= IDLE;
               vld_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = vld_q;
   assign busy          = busy_q;
   assign ovf           = ovf_q;

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.out_data[2*W*g +: W]   = re_q[g];
      assign bus.out_data[2*W*g+W +: W] = im_q[g];
   end
endmodule

// File: tb/tb_fft_r2_iter.sv
// Scoreboard bench for fft_r2_iter, N=8 W=16: one engine with SCALE=0 and
// one with SCALE=1, directed frames with hand-computed spectra.
module tb_fft_r2_iter;
   localparam int N  = 8;
   localparam int W  = 16;
   localparam int DW = N*2*W;

   typedef struct {
      logic [DW-1:0] data;
      logic          ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fft_r2_iter_if #(.N(N), .W(W)) bus0 ();
   fft_r2_iter_if #(.N(N), .W(W)) bus1 ();

   logic [1:0]        tw_addr0, tw_addr1;
   logic signed [W:0] tw_re0, tw_im0, tw_re1, tw_im1;
   logic              busy0, busy1, ovf0, ovf1;

   logic [DW-1:0] drv_data = '0;
   logic          drv_inv = 1'b0;
   logic          v0 = 1'b0, v1 = 1'b0, rdy0 = 1'b1, rdy1 = 1'b1;

   assign bus0.in_valid  = v0;
   assign bus0.in_data   = drv_data;
   assign bus0.inverse   = drv_inv;
   assign bus0.out_ready = rdy0;
   assign bus1.in_valid  = v1;
   assign bus1.in_data   = drv_data;
   assign bus1.inverse   = drv_inv;
   assign bus1.out_ready = rdy1;

   function automatic logic signed [W:0] rom_re(input logic [1:0] k);
      case (k)
         2'd0:    return 17'sd32768;
         2'd1:    return 17'sd23170;
         2'd2:    return 17'sd0;
         default: return -17'sd23170;
      endcase
   endfunction

   function automatic logic signed [W:0] rom_im(input logic [1:0] k);
      case (k)
         2'd0:    return 17'sd0;
         2'd1:    return -17'sd23170;
         2'd2:    return -17'sd32768;
         default: return -17'sd23170;
      endcase
   endfunction

   assign tw_re0 = rom_re(tw_addr0);
   assign tw_im0 = rom_im(tw_addr0);
   assign tw_re1 = rom_re(tw_addr1);
   assign tw_im1 = rom_im(tw_addr1);

   fft_r2_iter #(.N(N), .W(W), .SCALE(0)) u_s0 (
      .clk(clk), .reset(reset), .bus(bus0), .tw_addr(tw_addr0),
      .tw_re(tw_re0), .tw_im(tw_im0), .busy(busy0), .ovf(ovf0));

   fft_r2_iter #(.N(N), .W(W), .SCALE(1)) u_s1 (
      .clk(clk), .reset(reset), .bus(bus1), .tw_addr(tw_addr1),
      .tw_re(tw_re1), .tw_im(tw_im1), .busy(busy1), .ovf(ovf1));

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] put(input logic [DW-1:0] f, input int i, input int re, input int im);
      f[2*W*i +: W]   = W'(re);
      f[2*W*i+W +: W] = W'(im);
      return f;
   endfunction

   function automatic logic [DW-1:0] fill(input int re, input int im);
      logic [DW-1:0] f;
      f = '0;
      for (int i = 0; i < N; i++) f = put(f, i, re, im);
      return f;
   endfunction

   // Monitors: compare each presented result frame against the scoreboard.
   always @(negedge clk) begin
      if (!reset && bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) chk("s0_unexpected_frame", 1'b1, 1'b0);
         else begin
            exp_t e;
            e = q0.pop_front();
            chk("s0_frame_data", bus0.out_data, e.data);
            chk("s0_frame_ovf", DW'(ovf0), DW'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) chk("s1_unexpected_frame", 1'b1, 1'b0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("s1_frame_data", bus1.out_data, e.data);
            chk("s1_frame_ovf", DW'(ovf1), DW'(e.ovf));
         end
      end
   end

   // Offer a frame, wait (bounded) for acceptance, optionally log its expected result.
   task automatic send(input bit sel, input logic [DW-1:0] x, input logic inv,
                       input bit push, input logic [DW-1:0] ed, input logic eovf);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      e.data = ed;
      e.ovf  = eovf;
      @(posedge clk); #1;
      drv_data = x;
      drv_inv  = inv;
      if (sel) v1 = 1'b1; else v0 = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if ((sel ? bus1.in_ready : bus0.in_ready) == 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_within_bound", DW'(ok), DW'(1));
      if (ok) begin
         if (push) begin
            if (sel) q1.push_back(e); else q0.push_back(e);
         end
         @(posedge clk); #1;
      end
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   // Count edges from the accept edge until out_valid is seen.
   task automatic wait_out(input bit sel, output int cyc);
      cyc = 0;
      while (cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if ((sel ? bus1.out_valid : bus0.out_valid) == 1'b1) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] imp1000, e1000, c100, e800, e125, e_fwd, e_inv, x1, c20000, e_sat;
      int cyc;
      bit done;

      imp1000 = put('0, 0, 1000, 0);
      e1000   = fill(1000, 0);
      c100    = fill(100, 0);
      e800    = put('0, 0, 800, 0);
      e125    = fill(125, 0);
      x1      = put('0, 1, 1000, 0);
      c20000  = fill(20000, 0);
      e_sat   = put('0, 0, 32767, 0);
      e_fwd = '0;
      e_fwd = put(e_fwd, 0, 125, 0);   e_fwd = put(e_fwd, 1, 88, -89);
      e_fwd = put(e_fwd, 2, 0, -125);  e_fwd = put(e_fwd, 3, -89, -89);
      e_fwd = put(e_fwd, 4, -125, 0);  e_fwd = put(e_fwd, 5, -88, 88);
      e_fwd = put(e_fwd, 6, 0, 125);   e_fwd = put(e_fwd, 7, 88, 88);
      e_inv = '0;
      e_inv = put(e_inv, 0, 125, 0);   e_inv = put(e_inv, 1, 88, 88);
      e_inv = put(e_inv, 2, 0, 125);   e_inv = put(e_inv, 3, -89, 88);
      e_inv = put(e_inv, 4, -125, 0);  e_inv = put(e_inv, 5, -88, -88);
      e_inv = put(e_inv, 6, 0, -125);  e_inv = put(e_inv, 7, 88, -88);

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", DW'(bus0.in_ready), DW'(1));
      chk("reset_out_valid", DW'(bus0.out_valid), DW'(0));
      chk("reset_busy", DW'(busy0), DW'(0));
      chk("reset_ovf", DW'(ovf0), DW'(0));
      chk("reset_out_data", bus0.out_data, '0);
      chk("reset_tw_addr", DW'(tw_addr0), DW'(0));

      // Impulse, unscaled: flat spectrum, 12-cycle latency
      send(0, imp1000, 1'b0, 1, e1000, 1'b0);
      chk("comp_busy", DW'(busy0), DW'(1));
      wait_out(0, cyc);
      chk("latency_n8", DW'(cyc), DW'(12));

      // DC input, unscaled
      send(0, c100, 1'b0, 1, e800, 1'b0);

      // Scaled engine: impulse, then shifted impulse forward and inverse
      send(1, imp1000, 1'b0, 1, e125, 1'b0);
      send(1, x1, 1'b0, 1, e_fwd, 1'b0);
      send(1, x1, 1'b1, 1, e_inv, 1'b0);

      // Saturation raises ovf; next clean frame clears it
      send(0, c20000, 1'b0, 1, e_sat, 1'b1);
      wait_out(0, cyc);
      chk("ovf_held_in_done", DW'(ovf0), DW'(1));
      send(0, imp1000, 1'b0, 1, e1000, 1'b0);
      wait_out(0, cyc);
      chk("ovf_cleared", DW'(ovf0), DW'(0));

      // Back-pressure in DONE: output held, new frame ignored
      @(posedge clk); #1;
      rdy0 = 1'b0;
      send(0, imp1000, 1'b0, 1, e1000, 1'b0);
      wait_out(0, cyc);
      drv_data = c100;
      v0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_out_data", bus0.out_data, e1000);
         chk("hold_in_ready", DW'(bus0.in_ready), DW'(0));
         chk("hold_out_valid", DW'(bus0.out_valid), DW'(1));
      end
      @(posedge clk); #1;
      v0 = 1'b0;
      rdy0 = 1'b1;
      @(posedge clk); #1;
      chk("after_out_in_ready", DW'(bus0.in_ready), DW'(1));
      chk("after_out_valid", DW'(bus0.out_valid), DW'(0));
      chk("after_out_busy", DW'(busy0), DW'(0));

      // Reset in the middle of COMP aborts the frame
      send(0, c100, 1'b0, 0, '0, 1'b0);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_busy", DW'(busy0), DW'(0));
      chk("abort_out_valid", DW'(bus0.out_valid), DW'(0));
      chk("abort_out_data", bus0.out_data, '0);
      chk("abort_in_ready", DW'(bus0.in_ready), DW'(1));
      send(0, imp1000, 1'b0, 1, e1000, 1'b0);

      // Drain both engines
      done = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus0.in_ready && bus1.in_ready && q0.size() == 0 && q1.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_s0_queue", DW'(q0.size()), DW'(0));
      chk("drain_s1_queue", DW'(q1.size()), DW'(0));
      chk("drain_done", DW'(done), DW'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
